// File: rtl/fnd_scan_ctrl_if.sv
// Adder-result and FND pin bundle between the adder stage and the scan controller.
interface fnd_scan_ctrl_if;
  logic [3:0] i_sum;
  logic       i_carry;
  logic       i_load;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;

  modport master (output i_sum, i_carry, i_load, input o_fnd_com, o_fnd_font);
  modport slave  (input i_sum, i_carry, i_load, output o_fnd_com, o_fnd_font);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Captures the 5-bit adder result and scans it as two BCD digits on a 4-digit common-anode FND.
// Optional overflow blink (value > 15) is built when FND_OVF_BLINK_EN is defined.
module fnd_scan_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic            i_clk,
  input  logic            i_reset,
  fnd_scan_ctrl_if.slave  bus
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  if ((DIV < 2) || (BLINK_TICKS < 1)) begin : g_cfg_err
    $error("fnd_scan_ctrl: CLK_HZ/SCAN_HZ must be >= 2 and BLINK_TICKS >= 1");
  end

  function automatic logic [7:0] font_of(input logic [4:0] digit);
    case (digit)
      5'd0:    font_of = 8'hC0;
      5'd1:    font_of = 8'hF9;
      5'd2:    font_of = 8'hA4;
      5'd3:    font_of = 8'hB0;
      5'd4:    font_of = 8'h99;
      5'd5:    font_of = 8'h92;
      5'd6:    font_of = 8'h82;
      5'd7:    font_of = 8'hF8;
      5'd8:    font_of = 8'h80;
      5'd9:    font_of = 8'h90;
      default: font_of = 8'hFF;
    endcase
  endfunction

  logic [4:0]       value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic             tick_s;
  logic [4:0]       tens_s, ones_s, digit_s;
  logic             force_blank_s;

`ifdef FND_OVF_BLINK_EN
  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Blink phase flips once every BLINK_TICKS scan ticks.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick_s) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = {BW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end else begin
      bcnt_d  = bcnt_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bcnt_q  <= {BW{1'b0}};
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign force_blank_s = (value_q > 5'd15) && phase_q;
`else
  assign force_blank_s = 1'b0;
`endif

  // Capture, scan timing, BCD split and next output pattern.
  always_comb begin
    value_d = bus.i_load ? {bus.i_carry, bus.i_sum} : value_q;
    tick_s  = (cnt_q == CNT_MAX);
    cnt_d   = tick_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    idx_d   = tick_s ? idx_q + 2'd1 : idx_q;

    if (value_q >= 5'd30) begin
      tens_s = 5'd3;
      ones_s = value_q - 5'd30;
    end else if (value_q >= 5'd20) begin
      tens_s = 5'd2;
      ones_s = value_q - 5'd20;
    end else if (value_q >= 5'd10) begin
      tens_s = 5'd1;
      ones_s = value_q - 5'd10;
    end else begin
      tens_s = 5'd0;
      ones_s = value_q;
    end

    // Code 31 has no glyph and renders blank.
    case (idx_q)
      2'd0:    digit_s = ones_s;
      2'd1:    digit_s = (tens_s == 5'd0) ? 5'd31 : tens_s;
      default: digit_s = 5'd31;
    endcase

    com_d  = ~(4'b0001 << idx_q);
    font_d = force_blank_s ? 8'hFF : font_of(digit_s);
  end

  // State and output registers; reset leaves every digit dark.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      value_q <= 5'd0;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= 2'd0;
      com_q   <= 4'b1111;
      font_q  <= 8'hFF;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      font_q  <= font_d;
    end
  end

  assign bus.o_fnd_com  = com_q;
  assign bus.o_fnd_font = font_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl with DIV=4 and BLINK_TICKS=2.
module tb_fnd_scan_ctrl;
  localparam int DIV = 4;
  localparam int BT  = 2;

  logic i_clk = 1'b0;
  logic i_reset;
  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(250), .BLINK_TICKS(BT)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       ld;
    logic [3:0] sum;
    logic       carry;
    int         reps;
    logic [3:0] com;
    logic [7:0] font;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release and the captured value.
  int         n_m;
  int         val_m;
  logic [3:0] exp_com;
  logic [7:0] exp_font;
  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic predict();
    int idx, tens, ones;
    idx  = (n_m / DIV) % 4;
    tens = val_m / 10;
    ones = val_m % 10;
    exp_com = 4'b1111;
    exp_com[idx] = 1'b0;
    if (idx == 0)                  exp_font = glyph[ones];
    else if (idx == 1 && tens > 0) exp_font = glyph[tens];
    else                           exp_font = 8'hFF;
`ifdef FND_OVF_BLINK_EN
    if (val_m > 15 && (((n_m / DIV) / BT) % 2) == 1) exp_font = 8'hFF;
`endif
  endtask

  task automatic chk(input string name, input logic [3:0] ec, input logic [7:0] ef);
    checks++;
    if (bus.o_fnd_com !== ec || bus.o_fnd_font !== ef) begin
      errors++;
      $display("FAIL %s @%0t: com=%b font=%h expected com=%b font=%h",
               name, $time, bus.o_fnd_com, bus.o_fnd_font, ec, ef);
    end
  endtask

  task automatic cycle(input logic ld, input logic [3:0] s, input logic c);
    bus.i_load  = ld;
    bus.i_sum   = s;
    bus.i_carry = c;
    @(posedge i_clk);
    #1;
    predict();
    n_m++;
    if (ld) val_m = int'({c, s});
    bus.i_load = 1'b0;
  endtask

  task automatic run_random(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      logic       ld;
      logic [3:0] s;
      logic       c;
      ld = ($urandom_range(3) == 0);
      s  = 4'($urandom_range(15));
      c  = 1'($urandom_range(1));
      cycle(ld, s, c);
      chk(name, exp_com, exp_font);
    end
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 1'b0, 1, 4'b1110, 8'hC0};
    vecs[1]  = '{1'b1, 4'h7, 1'b0, 1, 4'b1110, 8'hC0};
    vecs[2]  = '{1'b0, 4'h0, 1'b0, 2, 4'b1110, 8'hF8};
    vecs[3]  = '{1'b0, 4'h0, 1'b0, 4, 4'b1101, 8'hFF};
    vecs[4]  = '{1'b0, 4'h0, 1'b0, 4, 4'b1011, 8'hFF};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 4, 4'b0111, 8'hFF};
    vecs[6]  = '{1'b1, 4'hA, 1'b1, 1, 4'b1110, 8'hF8};
    vecs[7]  = '{1'b0, 4'h0, 1'b0, 3, 4'b1110, 8'h82};
    vecs[8]  = '{1'b0, 4'h0, 1'b0, 4, 4'b1101, 8'hA4};
    vecs[9]  = '{1'b1, 4'hF, 1'b1, 1, 4'b1011, 8'hFF};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 3, 4'b1011, 8'hFF};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 4, 4'b0111, 8'hFF};
    vecs[12] = '{1'b0, 4'h0, 1'b0, 4, 4'b1110, 8'hF9};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 4, 4'b1101, 8'hB0};

    i_reset     = 1'b1;
    bus.i_load  = 1'b0;
    bus.i_sum   = 4'h0;
    bus.i_carry = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("in_reset", 4'b1111, 8'hFF);
    @(negedge i_clk);
    i_reset = 1'b0;
    n_m   = 0;
    val_m = 0;

    // Scan order, captures and BCD glyphs from a known alignment.
    for (int v = 0; v < 14; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        cycle(vecs[v].ld && (r == 0), vecs[v].sum, vecs[v].carry);
        chk($sformatf("vec%0d_r%0d", v, r), vecs[v].com, vecs[v].font);
      end
    end

    // Load of 10 on the edge where the index steps 0 -> 1.
    cycle(1'b1, 4'h9, 1'b0);
    repeat (10) cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0);
    chk("tick_load_old", 4'b1110, 8'h90);
    cycle(1'b0, 4'h0, 1'b0);
    chk("tick_load_new", 4'b1101, 8'hF9);
    repeat (11) cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    chk("tick_load_d0", 4'b1110, 8'hC0);

    run_random(300, "rand_a");

    // Asynchronous reset in the middle of a cycle.
    #3;
    i_reset = 1'b1;
    #1;
    chk("async_rst", 4'b1111, 8'hFF);
    @(negedge i_clk);
    i_reset = 1'b0;
    n_m   = 0;
    val_m = 0;
    cycle(1'b0, 4'h0, 1'b0);
    chk("post_rst", 4'b1110, 8'hC0);
    cycle(1'b0, 4'h0, 1'b0);
    chk("post_rst_hold", 4'b1110, 8'hC0);

    run_random(300, "rand_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
